// File: rtl/accum_pkg.sv
// Shared types and constants for the 8-bit accumulator and its operand feeder.
package accum_pkg;

  localparam int ACC_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    RESTART
  } feeder_state_t;

endpackage

// File: rtl/accum_sync_fifo.sv
// Synchronous FIFO with level-based full/empty and no write-to-read bypass.
module accum_sync_fifo
  import accum_pkg::*;
#(
  parameter int DATA_W = ACC_W,
  parameter int DEPTH  = 8
) (
  input  logic                     i_clk,
  input  logic                     ni_rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;

  assign o_rdata = mem[rd_ptr];
  assign o_level = level;
  assign o_full  = (level == LW'(DEPTH));
  assign o_empty = (level == '0);

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      mem[wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (i_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (i_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/accum_operand_feeder.sv
// Operand feeder for the accumulator: FIFO, idle filler and overflow bubble.
// Build option FEEDER_ZERO_SKIP_EN: zero bytes are acknowledged but not stored.
module accum_operand_feeder
  import accum_pkg::*;
#(
  parameter int DATA_W = ACC_W,
  parameter int DEPTH  = 8
) (
  input  logic                   i_clk,
  input  logic                   ni_rst,
  input  logic                   i_valid,
  input  logic [DATA_W-1:0]      i_data,
  output logic                   o_ready,
  input  logic                   i_ovf,
  output logic [DATA_W-1:0]      o_a,
  output logic                   o_a_valid,
  output logic                   o_restart,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int LW = $clog2(DEPTH) + 1;

  feeder_state_t     state;
  logic              push_hs;
  logic              push_wr;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [LW-1:0]     lvl_nxt;

  assign o_ready = !o_full;
  assign push_hs = i_valid && o_ready;

`ifdef FEEDER_ZERO_SKIP_EN
  assign push_wr = push_hs && (i_data != '0);
`else
  assign push_wr = push_hs;
`endif

  // Overflow wins over popping so nothing is consumed during the clear.
  assign pop = (state == FEED) && !i_ovf && !o_empty;

  always_comb begin
    lvl_nxt = o_level;
    if (push_wr && !pop) begin
      lvl_nxt = o_level + LW'(1);
    end else if (!push_wr && pop) begin
      lvl_nxt = o_level - LW'(1);
    end
  end

  accum_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .ni_rst  (ni_rst),
    .i_push  (push_wr),
    .i_wdata (i_data),
    .i_pop   (pop),
    .o_rdata (head),
    .o_level (o_level),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      state     <= IDLE;
      o_a       <= '0;
      o_a_valid <= 1'b0;
      o_restart <= 1'b0;
    end else begin
      o_a       <= pop ? head : '0;
      o_a_valid <= pop;
      o_restart <= (state == FEED) && i_ovf;
      unique case (state)
        IDLE: begin
          if (lvl_nxt != '0) begin
            state <= FEED;
          end
        end
        FEED: begin
          if (i_ovf) begin
            state <= RESTART;
          end else if (lvl_nxt == '0) begin
            state <= IDLE;
          end
        end
        RESTART: begin
          state <= (lvl_nxt != '0) ? FEED : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_operand_feeder.sv
// Scoreboard bench for accum_operand_feeder (default DEPTH = 8).
module tb_accum_operand_feeder;
  import accum_pkg::*;

  localparam int DW    = ACC_W;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          i_clk   = 1'b0;
  logic          ni_rst  = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data  = '0;
  logic          i_ovf   = 1'b0;
  logic          o_ready;
  logic [DW-1:0] o_a;
  logic          o_a_valid;
  logic          o_restart;
  logic [LW-1:0] o_level;
  logic          o_full;
  logic          o_empty;

  int          n_run    = 0;
  int          n_fail   = 0;
  int          restarts = 0;
  int          peak     = 0;
  int          r0;
  bit          mon_en   = 1'b0;
  logic [7:0]  sbq [$];

  accum_operand_feeder #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk     (i_clk),
    .ni_rst    (ni_rst),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .i_ovf     (i_ovf),
    .o_a       (o_a),
    .o_a_valid (o_a_valid),
    .o_restart (o_restart),
    .o_level   (o_level),
    .o_full    (o_full),
    .o_empty   (o_empty)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (int'(o_level) > peak) peak = int'(o_level);
  endtask

  task automatic push_byte(input logic [7:0] v);
    bit hs;
    bit done;
    done    = 1'b0;
    i_valid = 1'b1;
    i_data  = v;
    for (int k = 0; k < 64 && !done; k++) begin
      hs = o_ready;
      tick();
      done = hs;
    end
    i_valid = 1'b0;
    chk("push_handshake", 32'(done), 32'd1);
    if (done) begin
`ifdef FEEDER_ZERO_SKIP_EN
      if (v != 8'h00) sbq.push_back(v);
`else
      sbq.push_back(v);
`endif
    end
  endtask

  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_a_valid) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'(o_a_valid), 32'd0);
        end else begin
          chk("data", 32'(o_a), 32'(sbq.pop_front()));
        end
      end else begin
        chk("filler", 32'(o_a), 32'd0);
      end
      chk("ready_vs_full", 32'(o_ready), 32'(!o_full));
      chk("empty_vs_lvl", 32'(o_empty), 32'(o_level == '0));
      chk("full_vs_lvl", 32'(o_full), 32'(o_level == LW'(DEPTH)));
      if (o_restart) begin
        restarts++;
        chk("bubble_valid", 32'(o_a_valid), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] zs_lvl;
    // reset state
    ni_rst = 1'b0;
    repeat (2) tick();
    mon_en = 1'b1;
    chk("rst_a", 32'(o_a), 32'd0);
    chk("rst_a_valid", 32'(o_a_valid), 32'd0);
    chk("rst_restart", 32'(o_restart), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_level", 32'(o_level), 32'd0);
    ni_rst = 1'b1;
    repeat (3) tick();
    chk("idle_a_valid", 32'(o_a_valid), 32'd0);
    chk("idle_empty", 32'(o_empty), 32'd1);

    // single byte latency
    push_byte(8'h05);
    chk("single_lvl1", 32'(o_level), 32'd1);
    tick();
    chk("single_a", 32'(o_a), 32'h05);
    chk("single_av", 32'(o_a_valid), 32'd1);
    chk("single_lvl0", 32'(o_level), 32'd0);
    tick();
    chk("single_a2", 32'(o_a), 32'd0);
    chk("single_av2", 32'(o_a_valid), 32'd0);

    // back-pressure: a held overflow stalls all pops
    peak  = 0;
    i_ovf = 1'b1;
    fork
      begin
        for (int i = 1; i <= 10; i++) push_byte(8'(i));
      end
      begin
        repeat (12) tick();
        chk("bp_level", 32'(o_level), 32'd8);
        chk("bp_full", 32'(o_full), 32'd1);
        chk("bp_ready", 32'(o_ready), 32'd0);
        i_ovf = 1'b0;
      end
    join
    repeat (12) tick();
    chk("bp_peak", 32'(peak), 32'd8);
    chk("bp_drain", 32'(sbq.size()), 32'd0);

    // overflow bubble after the second pop
    r0 = restarts;
    repeat (3) push_byte(8'h80);
    i_ovf = 1'b1;
    tick();
    i_ovf = 1'b0;
    chk("ovf_restart", 32'(o_restart), 32'd1);
    chk("ovf_a", 32'(o_a), 32'd0);
    chk("ovf_av", 32'(o_a_valid), 32'd0);
    chk("ovf_lvl", 32'(o_level), 32'd1);
    repeat (6) tick();
    chk("ovf_pulses", 32'(restarts - r0), 32'd1);
    chk("ovf_drain", 32'(sbq.size()), 32'd0);

    // wrap-around at full rate
    peak = 0;
    for (int i = 0; i < 20; i++) push_byte(8'(i));
    repeat (4) tick();
    chk("wrap_peak_le2", 32'(peak <= 2), 32'd1);
    chk("wrap_drain", 32'(sbq.size()), 32'd0);

    // reset mid-stream discards stored data
    i_ovf = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h11 + 8'(i));
    chk("rm_lvl5", 32'(o_level), 32'd5);
    ni_rst = 1'b0;
    tick();
    sbq.delete();
    chk("rm_lvl0", 32'(o_level), 32'd0);
    chk("rm_a", 32'(o_a), 32'd0);
    chk("rm_av", 32'(o_a_valid), 32'd0);
    ni_rst = 1'b1;
    i_ovf  = 1'b0;
    repeat (6) tick();
    chk("rm_empty", 32'(o_empty), 32'd1);

    // zero bytes: skipped or stored depending on the build
`ifdef FEEDER_ZERO_SKIP_EN
    zs_lvl = 32'd2;
`else
    zs_lvl = 32'd4;
`endif
    i_ovf = 1'b1;
    push_byte(8'h00);
    push_byte(8'h03);
    push_byte(8'h00);
    push_byte(8'h07);
    chk("zs_level", 32'(o_level), zs_lvl);
    i_ovf = 1'b0;
    repeat (10) tick();
    chk("zs_drain", 32'(sbq.size()), 32'd0);
    chk("final_empty", 32'(o_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
